irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- CSR-mapped interrupt controller that replaces the plain OR of the GPIO controller interrupts in the board top level.
- Collects up to 8 interrupt sources (GPIO banks, watchdog, GPI), synchronises each one, latches events into a pending register and masks them with an enable register.
- Drives the single active-high `irq_out` that feeds the CPLD interrupt / RCW_SRC2 pin.
- Sits on the shared I2C-slave CSR bus with the same read-OR convention as every other CSR block.

Parameters:
- `BASE_ADDR`, 5'h08: CSR base; the block occupies `BASE_ADDR` .. `BASE_ADDR+3`.
- `NUM_IRQS`, 8: number of sources, 1..8. Unused bits read 0 and ignore writes.
- `DFL_ENABLE`, 8'h00: reset value of ENABLE.
- `DFL_MODE`, 8'h00: reset value of MODE (1 = edge, 0 = level).
- `HOLDOFF_TICKS`, 4: forced-low gap length in `ce` ticks (used only with the optional feature), 1..15.

Ports:
- `clk`  input  1  system clock
- `rst`  input  1  reset; asynchronous, active-high
- `csr_a`  input  5  CSR address
- `csr_di`  input  8  CSR write data
- `csr_we`  input  1  CSR write strobe, one `clk` cycle
- `csr_do`  output  8  CSR read data; 8'h00 when not addressed
- `ce`  input  1  single-cycle clock enable for the holdoff timer (`ce_32khz`)
- `irq_src`  input  `NUM_IRQS`  raw interrupt sources, active-high, asynchronous to `clk`
- `irq_out`  output  1  registered interrupt output, active-high

Behaviour:
- **Reset** (asynchronous, `rst`=1): all of the following are cleared or loaded immediately and held while `rst`=1.
  - sync stages s1, s2 and previous-value register p = 0.
  - STATUS = 0, ENABLE = `DFL_ENABLE`, MODE = `DFL_MODE`.
  - holdoff counter = 0, `irq_out` = 0.
- **Reset mid-operation**: pending events are lost and `irq_out` drops asynchronously.
- **Synchronisation**: on each `clk` edge, s1 <= `irq_src`, s2 <= s1, p <= s2.
- **Per-bit set condition**:
  - edge mode: s2 & ~p.
  - level mode: s2.
  - Because p resets to 0, a source already high at reset release produces exactly one edge event.
- **CSR map**: an address hits when `csr_a` == `BASE_ADDR` + n.
  - +0 STATUS: pending bits. Read returns STATUS. Write is W1C.
  - +1 ENABLE: read/write.
  - +2 MODE: read/write.
  - +3 RAW: read-only, returns s2. Writes are ignored.
- **Reads**: `csr_do` is combinational from `csr_a`, zero-latency; 8'h00 whenever no address hits.
- **Writes**: take effect on the `clk` edge where `csr_we`=1.
- **STATUS update** per bit each edge: STATUS <= (STATUS & ~w1c) | set.
  - Set wins over a simultaneous W1C.
  - In level mode, a W1C while the source is still high has no lasting effect: the bit re-sets the same edge.
- **STATUS is independent of ENABLE**: masked sources still latch and remain readable.
- **Output**: `irq_out` <= |(STATUS & ENABLE) & (holdoff == 0), registered.
- **Latency**: `irq_src` high before `clk` edge k gives s1 at k, s2 at k+1, STATUS at k+2, `irq_out`=1 after edge k+3.
- **Deassertion**:
  - W1C of the last enabled pending bit at edge j gives `irq_out`=0 after edge j+1.
  - Clearing an ENABLE bit behaves the same way.
- **Widths**: bits at or above `NUM_IRQS` in STATUS, ENABLE, MODE and RAW are constant 0.

Optional Feature:
- Macro: `IRQ_CTRL_HOLDOFF_EN`.
- **With the macro**:
  - A W1C write that clears at least one enabled pending bit while `irq_out`=1 loads holdoff = `HOLDOFF_TICKS`.
  - Holdoff decrements on each `ce` cycle while non-zero.
  - `irq_out` is forced 0 while holdoff != 0, so an edge-triggered SoC input sees a fresh rising edge if other enabled bits remain pending.
  - A reload during holdoff restarts the count.
  - Holdoff does not block STATUS updates.
- **Without the macro**:
  - holdoff is constant 0 and no counter is built.
  - `irq_out` stays high across a W1C when other enabled bits are pending.
  - `ce` is unused.

Test Plan:
1. Reset with `DFL_ENABLE`=8'h00, `DFL_MODE`=8'h01.
   - Read +1 -> 8'h00, read +2 -> 8'h01, `irq_out`=0.
   - Read of an unmapped address -> `csr_do`=8'h00.
2. Edge bit 0, ENABLE=8'h01: pulse `irq_src`[0] high for 5 cycles before edge k.
   - STATUS=8'h01 at k+2, `irq_out`=1 after k+3.
   - Write 8'h01 to +0 -> STATUS=8'h00, `irq_out`=0 one cycle later, with no re-set while the source stays low.
3. Level bit 2, ENABLE=8'h04, `irq_src`[2] held high: write 8'h04 to +0.
   - STATUS stays 8'h04, `irq_out` stays 1.
   - Drop the source, then W1C -> STATUS=8'h00, `irq_out`=0.
4. Masked source: ENABLE=8'h00, edge on bit 5.
   - STATUS=8'h20, `irq_out` stays 0.
   - Write ENABLE=8'h20 -> `irq_out`=1 one cycle later.
   - Edge on bit 5 in the same cycle as W1C 8'h20 -> STATUS bit 5 remains 1.
5. Holdoff with `IRQ_CTRL_HOLDOFF_EN`, `HOLDOFF_TICKS`=4, bits 0 and 1 pending and enabled: W1C 8'h01.
   - `irq_out`=0 for exactly 4 `ce` ticks, then returns to 1.
   - Without the macro, `irq_out` stays 1 throughout.
6. Assert `rst` mid-holdoff with STATUS=8'hFF.
   - `irq_out`=0 and STATUS=8'h00 immediately, asynchronously.
   - After release with `irq_src`=8'h80 held high (MODE bit 7 = edge, ENABLE bit 7 = 1), exactly one edge event is latched.

Source files
------------

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- CSR-mapped interrupt controller
//
// Collects up to NUM_IRQS asynchronous interrupt sources, synchronises each
// one, latches events into STATUS and combines STATUS with ENABLE into one
// registered, active-high irq_out.
//
// CSR map (offsets from BASE_ADDR):
//   +0 STATUS  pending bits, write-1-to-clear
//   +1 ENABLE  read/write mask for irq_out
//   +2 MODE    read/write, 1 = edge, 0 = level
//   +3 RAW     read-only, synchronised source levels
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   csr_a    CSR address
//   csr_di   CSR write data
//   csr_we   CSR write strobe (one clk cycle)
//   csr_do   CSR read data, combinational, 8'h00 when not addressed
//   ce       clock enable for the holdoff timer
//   irq_src  raw interrupt sources, active-high, asynchronous to clk
//   irq_out  registered interrupt output, active-high
//
// Optional feature macro: IRQ_CTRL_HOLDOFF_EN
//   When defined, a W1C that clears an enabled pending bit while irq_out is
//   high forces irq_out low for HOLDOFF_TICKS ce ticks, so an edge-triggered
//   receiver sees a fresh rising edge if other enabled bits remain pending.
//   When undefined, no counter is built and ce is unused.
// -----------------------------------------------------------------------------
module irq_ctrl #(
    parameter logic [4:0] BASE_ADDR     = 5'h08,
    parameter int         NUM_IRQS      = 8,
    parameter logic [7:0] DFL_ENABLE    = 8'h00,
    parameter logic [7:0] DFL_MODE      = 8'h00,
    parameter int         HOLDOFF_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic                ce,
    input  logic [NUM_IRQS-1:0] irq_src,
    output logic                irq_out
);

    // Bits at or above NUM_IRQS are held at 0 in every register.
    localparam logic [7:0] IRQ_MASK = 8'((9'd1 << NUM_IRQS) - 9'd1);

    logic [NUM_IRQS-1:0] s1;
    logic [NUM_IRQS-1:0] s2;
    logic [NUM_IRQS-1:0] p;

    logic [7:0] status_q;
    logic [7:0] enable_q;
    logic [7:0] mode_q;

    logic [7:0] s2_w;
    logic [7:0] p_w;
    logic [7:0] set_w;
    logic [7:0] w1c_w;
    logic [7:0] cleared_w;
    logic       hit_status;
    logic       hit_enable;
    logic       hit_mode;
    logic       hit_raw;
    logic       holdoff_zero;

    assign s2_w = 8'(s2);
    assign p_w  = 8'(p);

    assign hit_status = (csr_a == BASE_ADDR);
    assign hit_enable = (csr_a == BASE_ADDR + 5'd1);
    assign hit_mode   = (csr_a == BASE_ADDR + 5'd2);
    assign hit_raw    = (csr_a == BASE_ADDR + 5'd3);

    // Edge mode sets only on a rising synchronised level; level mode sets
    // every cycle the source is high, which makes a W1C under a still-high
    // level source a no-op.
    assign set_w = s2_w & (~mode_q | ~p_w) & IRQ_MASK;

    assign w1c_w = (csr_we && hit_status) ? (csr_di & IRQ_MASK) : 8'h00;

    // Enabled pending bits that really go from 1 to 0 this edge; a bit that
    // re-sets in the same cycle does not count as cleared.
    assign cleared_w = w1c_w & status_q & enable_q & ~set_w;

    // -------------------------------------------------------------------------
    // Synchroniser and previous-value register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            p  <= '0;
        end else begin
            s1 <= irq_src;
            s2 <= s1;
            p  <= s2;
        end
    end

    // -------------------------------------------------------------------------
    // CSR registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= 8'h00;
            enable_q <= DFL_ENABLE & IRQ_MASK;
            mode_q   <= DFL_MODE & IRQ_MASK;
        end else begin
            // Set wins over a simultaneous W1C.
            status_q <= (status_q & ~w1c_w) | set_w;
            if (csr_we && hit_enable) begin
                enable_q <= csr_di & IRQ_MASK;
            end
            if (csr_we && hit_mode) begin
                mode_q <= csr_di & IRQ_MASK;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Holdoff timer
    // -------------------------------------------------------------------------
`ifdef IRQ_CTRL_HOLDOFF_EN
    logic [3:0] holdoff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdoff_q <= 4'd0;
        end else if ((|cleared_w) && irq_out) begin
            // A reload during an active holdoff restarts the count.
            holdoff_q <= 4'(HOLDOFF_TICKS);
        end else if (ce && (holdoff_q != 4'd0)) begin
            holdoff_q <= holdoff_q - 4'd1;
        end
    end

    assign holdoff_zero = (holdoff_q == 4'd0);
`else
    logic unused_holdoff;

    assign unused_holdoff = ^{ce, cleared_w};
    assign holdoff_zero   = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Interrupt output
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_out <= 1'b0;
        end else begin
            irq_out <= (|(status_q & enable_q)) && holdoff_zero;
        end
    end

    // -------------------------------------------------------------------------
    // Read mux: zero-latency, 8'h00 when no offset hits so the shared bus can
    // OR all CSR blocks together.
    // -------------------------------------------------------------------------
    always_comb begin
        csr_do = 8'h00;
        if (hit_status) begin
            csr_do = status_q;
        end else if (hit_enable) begin
            csr_do = enable_q;
        end else if (hit_mode) begin
            csr_do = mode_q;
        end else if (hit_raw) begin
            csr_do = s2_w & IRQ_MASK;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl -- self-checking bench for irq_ctrl
//
// Inputs change 1 time unit after the rising edge. Each check request names
// a CSR address plus the expected {irq_out, csr_do}; the expected value is
// pushed into exp_q and a monitor compares at the following falling edge.
// Build with the same IRQ_CTRL_HOLDOFF_EN setting as the design.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

`ifdef IRQ_CTRL_HOLDOFF_EN
    localparam bit HO = 1'b1;
`else
    localparam bit HO = 1'b0;
`endif

    // irq_out level expected while a holdoff is in force
    localparam logic HI = HO ? 1'b0 : 1'b1;

    localparam logic [4:0] A_STATUS = 5'h08;
    localparam logic [4:0] A_ENABLE = 5'h09;
    localparam logic [4:0] A_MODE   = 5'h0A;
    localparam logic [4:0] A_RAW    = 5'h0B;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    logic       ce;
    logic [7:0] irq_src;
    logic       irq_out;

    logic       req = 1'b0;
    logic [8:0] exp_q[$];
    string      name_q[$];
    int         n_vec = 0;
    int         n_bad = 0;

    irq_ctrl #(
        .BASE_ADDR    (5'h08),
        .NUM_IRQS     (8),
        .DFL_ENABLE   (8'h00),
        .DFL_MODE     (8'h01),
        .HOLDOFF_TICKS(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .csr_a  (csr_a),
        .csr_di (csr_di),
        .csr_we (csr_we),
        .csr_do (csr_do),
        .ce     (ce),
        .irq_src(irq_src),
        .irq_out(irq_out)
    );

    // -------------------------------------------------------------------------
    // Clock
    // -------------------------------------------------------------------------
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (req) begin
            logic [8:0] got;
            logic [8:0] exp;
            string      nm;
            got = {irq_out, csr_do};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard: got irq_out=%b csr_do=%h but no expected entry",
                         got[8], got[7:0]);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL %s: irq_out=%b csr_do=%h, expected irq_out=%b csr_do=%h",
                             nm, got[8], got[7:0], exp[8], exp[7:0]);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input logic [4:0] a, input logic [7:0] d,
                       input logic irq, input string nm);
        csr_a = a;
        exp_q.push_back({irq, d});
        name_q.push_back(nm);
        req = 1'b1;
        step();
        req   = 1'b0;
        csr_a = 5'h00;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        step();
        csr_we = 1'b0;
        csr_a  = 5'h00;
        csr_di = 8'h00;
    endtask

    // Runs the holdoff timer out so the next scenario starts clean.
    task automatic drain_ce();
        ce = 1'b1;
        idle(5);
        ce = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst     = 1'b1;
        csr_a   = 5'h00;
        csr_di  = 8'h00;
        csr_we  = 1'b0;
        ce      = 1'b0;
        irq_src = 8'h00;

        // 1: reset values, unmapped reads, RAW is read-only
        idle(2);
        chk(A_ENABLE, 8'h00, 1'b0, "rst_enable");
        chk(A_MODE,   8'h01, 1'b0, "rst_mode");
        rst = 1'b0;
        chk(A_ENABLE, 8'h00, 1'b0, "enable_after_rel");
        chk(A_MODE,   8'h01, 1'b0, "mode_after_rel");
        chk(A_STATUS, 8'h00, 1'b0, "status_after_rel");
        chk(5'h1F,    8'h00, 1'b0, "unmapped_1f");
        chk(5'h07,    8'h00, 1'b0, "unmapped_below");
        chk(5'h0C,    8'h00, 1'b0, "unmapped_above");
        wr(A_RAW, 8'hFF);
        chk(A_RAW,    8'h00, 1'b0, "raw_ignores_write");

        // 2: edge on bit 0, latency and W1C deassertion
        wr(A_ENABLE, 8'h01);
        irq_src = 8'h01;
        chk(A_STATUS, 8'h00, 1'b0, "edge_k_minus1");
        chk(A_RAW,    8'h00, 1'b0, "edge_raw_k");
        chk(A_RAW,    8'h01, 1'b0, "edge_raw_k1");
        chk(A_STATUS, 8'h01, 1'b0, "edge_status_k2");
        chk(A_STATUS, 8'h01, 1'b1, "edge_irq_k3");
        irq_src = 8'h00;
        wr(A_STATUS, 8'h01);
        chk(A_STATUS, 8'h00, 1'b1, "edge_w1c_j");
        chk(A_STATUS, 8'h00, 1'b0, "edge_w1c_j1");
        chk(A_STATUS, 8'h00, 1'b0, "edge_no_reset");
        drain_ce();

        // 3: level bit 2 held high resists W1C
        wr(A_ENABLE, 8'h04);
        irq_src = 8'h04;
        idle(4);
        chk(A_STATUS, 8'h04, 1'b1, "level_pending");
        wr(A_STATUS, 8'h04);
        chk(A_STATUS, 8'h04, 1'b1, "level_w1c_held");
        chk(A_STATUS, 8'h04, 1'b1, "level_w1c_held2");
        irq_src = 8'h00;
        idle(4);
        wr(A_STATUS, 8'h04);
        chk(A_STATUS, 8'h00, 1'b1, "level_w1c_low_j");
        chk(A_STATUS, 8'h00, 1'b0, "level_w1c_low_j1");
        drain_ce();
        chk(A_STATUS, 8'h00, 1'b0, "level_cleared");

        // 4: masked source, late enable, set beats simultaneous W1C
        wr(A_ENABLE, 8'h00);
        wr(A_MODE,   8'h21);
        chk(A_MODE,   8'h21, 1'b0, "mode_rw");
        irq_src = 8'h20;
        idle(3);
        irq_src = 8'h00;
        chk(A_STATUS, 8'h20, 1'b0, "masked_latched");
        chk(A_STATUS, 8'h20, 1'b0, "masked_no_irq");
        wr(A_ENABLE, 8'h20);
        chk(A_ENABLE, 8'h20, 1'b0, "enable_write_j");
        chk(A_STATUS, 8'h20, 1'b1, "enable_write_j1");
        irq_src = 8'h20;
        idle(2);
        wr(A_STATUS, 8'h20);
        chk(A_STATUS, 8'h20, 1'b1, "set_beats_w1c");
        chk(A_STATUS, 8'h20, 1'b1, "set_beats_w1c2");
        irq_src = 8'h00;
        wr(A_STATUS, 8'h20);
        drain_ce();
        chk(A_STATUS, 8'h00, 1'b0, "masked_cleared");

        // 5: holdoff with bits 0 and 1 pending
        wr(A_MODE,   8'h83);
        wr(A_ENABLE, 8'h03);
        irq_src = 8'h03;
        idle(3);
        irq_src = 8'h00;
        chk(A_STATUS, 8'h03, 1'b0, "ho_pending");
        chk(A_STATUS, 8'h03, 1'b1, "ho_irq_up");
        wr(A_STATUS, 8'h01);
        chk(A_STATUS, 8'h02, 1'b1, "ho_w1c_j");
        chk(A_STATUS, 8'h02, HI,   "ho_w1c_j1");
        for (int t = 1; t <= 4; t++) begin
            ce = 1'b1;
            step();
            ce = 1'b0;
            chk(A_STATUS, 8'h02, HI, $sformatf("ho_tick%0d", t));
        end
        chk(A_STATUS, 8'h02, 1'b1, "ho_released");

        // 6: asynchronous reset mid-holdoff, one edge event after release
        wr(A_ENABLE, 8'hFF);
        irq_src = 8'hFF;
        idle(3);
        irq_src = 8'h00;
        idle(2);
        wr(A_STATUS, 8'h01);
        irq_src = 8'h01;
        idle(3);
        irq_src = 8'h00;
        chk(A_STATUS, 8'hFF, HI,   "all_pending");
        rst     = 1'b1;
        irq_src = 8'h80;
        chk(A_STATUS, 8'h00, 1'b0, "async_rst_status");
        chk(A_ENABLE, 8'h00, 1'b0, "async_rst_enable");
        chk(A_MODE,   8'h01, 1'b0, "async_rst_mode");
        rst = 1'b0;
        wr(A_MODE,   8'h80);
        wr(A_ENABLE, 8'h80);
        step();
        chk(A_STATUS, 8'h80, 1'b0, "post_rst_event");
        chk(A_STATUS, 8'h80, 1'b1, "post_rst_irq");
        wr(A_STATUS, 8'h80);
        chk(A_STATUS, 8'h00, 1'b1, "post_rst_w1c_j");
        chk(A_STATUS, 8'h00, 1'b0, "post_rst_w1c_j1");
        chk(A_STATUS, 8'h00, 1'b0, "single_event");
        chk(A_RAW,    8'h80, 1'b0, "raw_high");

        // Final report
        idle(2);
        if (exp_q.size() != 0) begin
            n_bad += exp_q.size();
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
